// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_cycle_ctrl                                             |
// | Description : Main control FSM of the multi-cycle MIPS-subset CPU. It      |
// |               sequences fetch/decode/execute/memory/write-back over a      |
// |               shared ALU and a unified memory with a ready handshake, and  |
// |               halts on an illegal instruction or a memory timeout.         |
// | Options     : MC_PERF_CNT_EN adds instr_cnt / cycle_cnt counter outputs.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multi_cycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             rs_eq_rt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic [1:0]       err_code
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // Width holds 0..MEM_TIMEOUT and stays at least one bit when timeouts are off
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_err_code;
  logic [1:0]          w_next_err;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                w_mem_wait;
  logic                w_timeout;
  logic                w_funct_ok;

  assign w_funct_ok = (funct == 6'b100001) || (funct == 6'b100011) ||
                      (funct == 6'b000000) || (funct == 6'b100101);
  assign w_mem_wait = mem_req && !mem_ready;
  // The timeout fires on the wait cycle that brings the count to MEM_TIMEOUT
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait &&
                      (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state and error-code selection
  always_comb begin
    w_next_state = r_state;
    w_next_err   = r_err_code;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
          w_next_err   = 2'd3;
        end
      end
      S_DECODE: begin
        case (opcode)
          c_OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next_state = S_EXEC_R;
            end else begin
              w_next_state = S_HALT;
              w_next_err   = 2'd2;
            end
          end
          c_OP_ADDIU, c_OP_ORI: w_next_state = S_EXEC_I;
          c_OP_LW, c_OP_SW:     w_next_state = S_MEM_ADDR;
          c_OP_BEQ:             w_next_state = S_BRANCH;
          c_OP_J:               w_next_state = S_JUMP;
          default: begin
            w_next_state = S_HALT;
            w_next_err   = 2'd1;
          end
        endcase
      end
      S_EXEC_R:   w_next_state = S_WB_R;
      S_EXEC_I:   w_next_state = S_WB_I;
      S_MEM_ADDR: w_next_state = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          w_next_state = (r_state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (w_timeout) begin
          w_next_state = S_HALT;
          w_next_err   = 2'd3;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, error code and memory wait counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_err_code <= 2'd0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_err_code <= w_next_err;
      if (w_mem_wait && (w_next_state == r_state)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Moore decode of the datapath controls; only FETCH's IR/PC loads look at mem_ready
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE, S_MEM_ADDR: begin
        alu_src_b = 2'd2;
        alu_op    = 2'b01;
      end
      S_EXEC_R, S_WB_R: begin
        alu_op    = 2'b10;
        reg_write = (r_state == S_WB_R);
        reg_dst   = (r_state == S_WB_R);
      end
      S_EXEC_I, S_WB_I: begin
        alu_op    = (opcode == c_OP_ORI) ? 2'b11 : 2'b01;
        alu_src_b = (opcode == c_OP_ORI) ? 2'd3 : 2'd2;
        reg_write = (r_state == S_WB_I);
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = (r_state == S_MEM_WR);
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        pc_src   = 2'd1;
        pc_write = rs_eq_rt;
      end
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign err_code = r_err_code;

`ifdef MC_PERF_CNT_EN
  // Retire count on every FETCH entry that ends an instruction; cycles run outside IDLE/HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if ((w_next_state == S_FETCH) && (r_state != S_FETCH) && (r_state != S_IDLE)) begin
        instr_cnt <= instr_cnt + 1'b1;
      end
      if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multi_cycle_ctrl                                          |
// | Description : Table-driven cycle-by-cycle bench for multi_cycle_ctrl plus  |
// |               hand-written halt, timeout and async-reset sequences.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       rs_eq_rt = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_b, alu_op, err_code;
  logic       reg_write, reg_dst, mem_to_reg, halted;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instr_cnt, cycle_cnt;
`endif

  multi_cycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rs_eq_rt(rs_eq_rt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted),
`ifdef MC_PERF_CNT_EN
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt),
`endif
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs:
  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_b, alu_op,
  //  reg_write, reg_dst, mem_to_reg, halted, err_code}
  logic [16:0] w_out;
  assign w_out = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_b,
                  alu_op, reg_write, reg_dst, mem_to_reg, halted, err_code};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        eq;
    logic        rdy;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [16:0] expo(input int mreq, input int mwe, input int iod,
                                       input int irw, input int pcw, input int pcs,
                                       input int srcb, input int aop, input int rw,
                                       input int rd, input int m2r, input int h,
                                       input int err);
    expo = {mreq[0], mwe[0], iod[0], irw[0], pcw[0], pcs[1:0], srcb[1:0], aop[1:0],
            rw[0], rd[0], m2r[0], h[0], err[1:0]};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                     input logic rdy, input logic [16:0] exp, input string name);
    vec_t v;
    v.op = op; v.fn = fn; v.eq = eq; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // One clock per call: starts and ends at a falling edge
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                       input logic rdy, input logic [16:0] exp, input string name);
    opcode = op; funct = fn; rs_eq_rt = eq; mem_ready = rdy;
    #1;
    check(name, w_out, exp);
    @(negedge clk);
  endtask

  logic [16:0] E_IDLE, E_FETCH, E_FETCHW, E_DEC, E_EXR, E_WBR, E_EXORI, E_WBORI;
  logic [16:0] E_EXADD, E_WBADD, E_MWR, E_MRD, E_WBM, E_BR0, E_BR1, E_JMP;
  logic [16:0] E_H1, E_H2, E_H3;

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("reset_state", w_out, E_IDLE);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDIU = 6'b001001, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADDU = 6'b100001, FN_BAD = 6'b101010;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                mrq mwe iod irw pcw pcs srb aop rw rd m2r h err
    E_IDLE   = expo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_FETCH  = expo(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
    E_FETCHW = expo(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    E_DEC    = expo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    E_EXR    = expo(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    E_WBR    = expo(0, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    E_EXORI  = expo(0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0);
    E_WBORI  = expo(0, 0, 0, 0, 0, 0, 3, 3, 1, 0, 0, 0, 0);
    E_EXADD  = expo(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    E_WBADD  = expo(0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
    E_MWR    = expo(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_MRD    = expo(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    E_WBM    = expo(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    E_BR0    = expo(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    E_BR1    = expo(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    E_JMP    = expo(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    E_H1     = expo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    E_H2     = expo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    E_H3     = expo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);

    // Instruction stream from reset; one row per clock
    add(OP_R, FN_ADDU, 0, 1, E_IDLE, "idle_ready_ignored");
    add(OP_R, FN_ADDU, 0, 1, E_FETCH, "addu_fetch");
    add(OP_R, FN_ADDU, 0, 1, E_DEC, "addu_decode");
    add(OP_R, FN_ADDU, 0, 1, E_EXR, "addu_exec");
    add(OP_R, FN_ADDU, 0, 1, E_WBR, "addu_wb");
    add(OP_ORI, 0, 0, 1, E_FETCH, "ori_fetch");
    add(OP_ORI, 0, 0, 1, E_DEC, "ori_decode");
    add(OP_ORI, 0, 0, 1, E_EXORI, "ori_exec");
    add(OP_ORI, 0, 0, 1, E_WBORI, "ori_wb");
    add(OP_ADDIU, 0, 0, 1, E_FETCH, "addiu_fetch");
    add(OP_ADDIU, 0, 0, 1, E_DEC, "addiu_decode");
    add(OP_ADDIU, 0, 0, 1, E_EXADD, "addiu_exec");
    add(OP_ADDIU, 0, 0, 1, E_WBADD, "addiu_wb");
    add(OP_SW, 0, 0, 1, E_FETCH, "sw_fetch");
    add(OP_SW, 0, 0, 1, E_DEC, "sw_decode");
    add(OP_SW, 0, 0, 1, E_DEC, "sw_memaddr");
    add(OP_SW, 0, 0, 1, E_MWR, "sw_memwr");
    add(OP_LW, 0, 0, 1, E_FETCH, "lw_fetch");
    add(OP_LW, 0, 0, 1, E_DEC, "lw_decode");
    add(OP_LW, 0, 0, 0, E_DEC, "lw_memaddr");
    add(OP_LW, 0, 0, 0, E_MRD, "lw_memrd_wait1");
    add(OP_LW, 0, 0, 0, E_MRD, "lw_memrd_wait2");
    add(OP_LW, 0, 0, 0, E_MRD, "lw_memrd_wait3");
    add(OP_LW, 0, 0, 1, E_MRD, "lw_memrd_done");
    add(OP_LW, 0, 0, 1, E_WBM, "lw_wbmem");
    add(OP_BEQ, 0, 0, 0, E_FETCHW, "beq0_fetch_wait");
    add(OP_BEQ, 0, 0, 1, E_FETCH, "beq0_fetch");
    add(OP_BEQ, 0, 0, 1, E_DEC, "beq0_decode");
    add(OP_BEQ, 0, 0, 1, E_BR0, "beq0_branch");
    add(OP_BEQ, 0, 1, 1, E_FETCH, "beq1_fetch");
    add(OP_BEQ, 0, 1, 1, E_DEC, "beq1_decode");
    add(OP_BEQ, 0, 1, 1, E_BR1, "beq1_branch");
    add(OP_J, 0, 0, 1, E_FETCH, "j_fetch");
    add(OP_J, 0, 0, 1, E_DEC, "j_decode");
    add(OP_J, 0, 0, 1, E_JMP, "j_jump");
    add(OP_BAD, 0, 0, 1, E_FETCH, "badop_fetch");
    add(OP_BAD, 0, 0, 1, E_DEC, "badop_decode");
    add(OP_BAD, 0, 0, 1, E_H1, "badop_halt1");
    add(OP_BAD, 0, 0, 1, E_H1, "badop_halt2");
    add(OP_J, 0, 0, 1, E_H1, "badop_halt3");

    @(negedge clk);
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].fn, vecs[i].eq, vecs[i].rdy, vecs[i].exp, vecs[i].name);
    end

    // Illegal funct halts with err 2 and stays halted for 20 cycles
    do_reset();
    apply(OP_R, FN_BAD, 0, 1, E_IDLE, "badfn_idle");
    apply(OP_R, FN_BAD, 0, 1, E_FETCH, "badfn_fetch");
    apply(OP_R, FN_BAD, 0, 1, E_DEC, "badfn_decode");
    for (int i = 0; i < 20; i++) begin
      apply(OP_ADDIU, 0, 1, 1, E_H2, "badfn_halt_hold");
    end

    // Memory never answers in FETCH: 16 wait cycles then HALT err 3
    do_reset();
    apply(OP_R, FN_ADDU, 0, 0, E_IDLE, "tmo_idle");
    for (int i = 0; i < 16; i++) begin
      apply(OP_R, FN_ADDU, 0, 0, E_FETCHW, "tmo_fetch_wait");
    end
    apply(OP_R, FN_ADDU, 0, 0, E_H3, "tmo_halt");
    apply(OP_R, FN_ADDU, 0, 1, E_H3, "tmo_halt_hold");
`ifdef MC_PERF_CNT_EN
    check_int("tmo_instr_cnt", instr_cnt, 0);
    check_int("tmo_cycle_cnt", cycle_cnt, 16);
`endif

    // Ready arriving on the 16th wait cycle completes the access instead
    do_reset();
    apply(OP_R, FN_ADDU, 0, 0, E_IDLE, "win_idle");
    for (int i = 0; i < 15; i++) begin
      apply(OP_R, FN_ADDU, 0, 0, E_FETCHW, "win_fetch_wait");
    end
    apply(OP_R, FN_ADDU, 0, 1, E_FETCH, "win_fetch_done");
    apply(OP_R, FN_ADDU, 0, 1, E_DEC, "win_decode");
    apply(OP_R, FN_ADDU, 0, 1, E_EXR, "win_exec");

    // Async reset in the middle of a load drops mem_req at once
    do_reset();
    apply(OP_LW, 0, 0, 1, E_IDLE, "rstmid_idle");
    apply(OP_LW, 0, 0, 1, E_FETCH, "rstmid_fetch");
    apply(OP_LW, 0, 0, 1, E_DEC, "rstmid_decode");
    apply(OP_LW, 0, 0, 1, E_DEC, "rstmid_memaddr");
    #1;
    check("rstmid_memrd", w_out, E_MRD);
    #1;
    rst = 1'b1;
    #1;
    check_int("rstmid_req_drop", mem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    apply(OP_LW, 0, 0, 1, E_IDLE, "rstmid_after_idle");
    apply(OP_LW, 0, 0, 1, E_FETCH, "rstmid_after_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
